image_seq_ctl: RTL and testbench
================================

IMAGE_SEQ_CTL -- requirements
Module: image_seq_ctl

Interface
REQ-001 Parameter FRAMES_PER_IMG, default 60, frames each image is held in AUTO state (range 1..255).
REQ-002 Parameter X_START, default 0, reset/static x position of image (12 bit).
REQ-003 Parameter Y_START, default 0, reset/static y position of image (12 bit).
REQ-004 clk  input  1  system pixel clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in  vga_if.in  -  timing stream; only vblnk is used.
REQ-007 btn_next  input  1  synchronized level; rising edge requests next image.
REQ-008 btn_pause  input  1  synchronized level; rising edge toggles pause.
REQ-009 img_sel  output  3  selected image index 0..NUM_IMG-1, feeds the image draw stage's ROM mux.
REQ-010 img_xpos  output  12  image top-left x.
REQ-011 img_ypos  output  12  image top-left y.
REQ-012 paused  output  1  high while in PAUSED state.

Function
REQ-013 Frame start SHALL be the cycle after a 0->1 transition of in.vblnk (registered edge detect); all output updates SHALL occur only on that cycle.
REQ-014 FSM states AUTO and PAUSED; btn_pause rising edge toggles AUTO<->PAUSED on the following cycle, independent of frame start.
REQ-015 In AUTO, frame counter increments per frame start; when counter = FRAMES_PER_IMG-1 at frame start, counter clears to 0 and img_sel advances.
REQ-016 In PAUSED, frame counter and img_sel hold, except for a pending next request.
REQ-017 btn_next rising edge sets a pending flag; at next frame start, img_sel advances, counter clears, flag clears; works in both states.
REQ-018 Auto-advance and pending next at the same frame start SHALL advance img_sel by exactly one.
REQ-019 btn_next edge on the same cycle as frame start SHALL be applied at the following frame start, not lost.
REQ-020 img_sel advance: NUM_IMG-1 wraps to 0; values >= NUM_IMG never produced.
REQ-021 Outputs are registered; latency from frame start edge detect to output change = 1 clk.

Reset
REQ-022 On rst low: img_sel=0, img_xpos=X_START, img_ypos=Y_START, paused=0, state AUTO, counter 0, pending flag 0, edge registers 0.
REQ-023 Reset asserted mid-frame or mid-hold SHALL discard pending requests; first advance after release occurs FRAMES_PER_IMG frame starts later.

Configuration
REQ-024 Macro IMAGE_SEQ_BOUNCE_EN defined: at each frame start in AUTO, img_xpos/img_ypos move 1 pixel per axis; direction per axis reverses on reaching 0 or (screen dimension - IMG_W/IMG_H); position never leaves that range; position holds in PAUSED.
REQ-025 Macro undefined: img_xpos=X_START and img_ypos=Y_START constantly; no direction registers synthesized.
REQ-026 Bounce arithmetic SHALL be 12-bit unsigned with bound compare before update (no underflow wrap).

Structure
REQ-027 vga_pkg SHALL hold NUM_IMG (6), IMG_W, IMG_H and the state enum typedef; screen width/height constants taken from vga_pkg.
REQ-028 One sub-module rise_edge_det (1-bit registered rising-edge detector, async active-low reset) SHALL be instantiated for vblnk, btn_next, btn_pause.

Verification
REQ-029 FRAMES_PER_IMG=2, 13 frame starts, no buttons -> img_sel sequence 0,0,1,1,2,2,3,3,4,4,5,5,0 (wrap).
REQ-030 btn_pause pulse, then 5 frames -> paused=1, img_sel constant; second pulse -> paused=0, advancing resumes.
REQ-031 PAUSED, btn_next pulse mid-frame -> img_sel +1 exactly at next frame start, counter 0, still paused.
REQ-032 btn_next coincident with auto-advance frame start at img_sel=5 -> img_sel=0 (single step), then one further step next frame start.
REQ-033 rst low mid-hold with pending next -> all outputs reset values; no advance until 2 frame starts after release.
REQ-034 IMAGE_SEQ_BOUNCE_EN, X_START=1 moving left -> xpos 1,0,1,2; at right bound xpos reverses without exceeding screen width - IMG_W.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA geometry, image-set constants and sequencer types.
// The bounce helper is used by image_seq_ctl only when IMAGE_SEQ_BOUNCE_EN is defined.
package vga_pkg;

   localparam int H_ACTIVE = 800;
   localparam int V_ACTIVE = 600;
   localparam int NUM_IMG  = 6;
   localparam int IMG_W    = 128;
   localparam int IMG_H    = 96;

   typedef enum logic {
      ST_AUTO   = 1'b0,
      ST_PAUSED = 1'b1
   } seq_state_t;

   typedef struct packed {
      logic [11:0] pos;
      logic        dec;
   } axis_t;

   function automatic logic [2:0] next_img(input logic [2:0] sel);
      return (sel == 3'(NUM_IMG - 1)) ? 3'd0 : sel + 3'd1;
   endfunction

   // The limit is compared before stepping, so the position never wraps below 0 or passes lim.
   function automatic axis_t bounce_step(input axis_t a, input logic [11:0] lim);
      axis_t r;
      r = a;
      if (a.dec) begin
         if (a.pos == 12'd0) begin
            r.dec = 1'b0;
            r.pos = 12'd1;
         end else begin
            r.pos = a.pos - 12'd1;
         end
      end else begin
         if (a.pos >= lim) begin
            r.dec = 1'b1;
            r.pos = lim - 12'd1;
         end else begin
            r.pos = a.pos + 12'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/vga_if.sv
// Video timing stream as seen by the image sequencer; vblnk marks vertical blanking.
interface vga_if;
   logic vblnk;

   modport in  (input  vblnk);
   modport out (output vblnk);
endinterface

// File: rtl/image_seq_ctl_rise_edge_det.sv
// One-bit registered rising-edge detector: rise is high for the cycle after d goes 0->1.
module rise_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic prev_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_reg <= 1'b0;
         rise     <= 1'b0;
      end else begin
         prev_reg <= d;
         rise     <= d & ~prev_reg;
      end
   end

endmodule

// File: rtl/image_seq_ctl.sv
// Image slideshow sequencer: steps img_sel every FRAMES_PER_IMG frames, with pause and next buttons.
// Define IMAGE_SEQ_BOUNCE_EN to make the image bounce around the screen while not paused.
module image_seq_ctl
   import vga_pkg::*;
#(
   parameter int          FRAMES_PER_IMG = 60,
   parameter logic [11:0] X_START        = 12'd0,
   parameter logic [11:0] Y_START        = 12'd0
) (
   input  logic        clk,
   input  logic        rst,
   vga_if.in           in,
   input  logic        btn_next,
   input  logic        btn_pause,
   output logic [2:0]  img_sel,
   output logic [11:0] img_xpos,
   output logic [11:0] img_ypos,
   output logic        paused
);

   localparam int EV_FRAME = 0;
   localparam int EV_NEXT  = 1;
   localparam int EV_PAUSE = 2;

   logic [2:0] raw;
   logic [2:0] rise;

   assign raw = {btn_pause, btn_next, in.vblnk};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_edge
         rise_edge_det u_det (
            .clk  (clk),
            .rst  (rst),
            .d    (raw[gi]),
            .rise (rise[gi])
         );
      end
   endgenerate

   logic frame_start;
   logic next_rise;
   logic pause_rise;

   assign frame_start = rise[EV_FRAME];
   assign next_rise   = rise[EV_NEXT];
   assign pause_rise  = rise[EV_PAUSE];

   seq_state_t state_reg;
   logic [7:0] cnt_reg;
   logic       pending_reg;
   logic       advance;

   // A pending next and an expiring hold collapse into one step.
   assign advance = pending_reg |
                    ((state_reg == ST_AUTO) && (cnt_reg == 8'(FRAMES_PER_IMG - 1)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= ST_AUTO;
         cnt_reg     <= 8'd0;
         pending_reg <= 1'b0;
         img_sel     <= 3'd0;
      end else begin
         if (pause_rise)
            state_reg <= (state_reg == ST_AUTO) ? ST_PAUSED : ST_AUTO;

         // A next edge landing on a frame start survives to the following frame.
         if (next_rise)
            pending_reg <= 1'b1;
         else if (frame_start)
            pending_reg <= 1'b0;

         if (frame_start) begin
            if (advance) begin
               cnt_reg <= 8'd0;
               img_sel <= next_img(img_sel);
            end else if (state_reg == ST_AUTO) begin
               cnt_reg <= cnt_reg + 8'd1;
            end
         end
      end
   end

   assign paused = (state_reg == ST_PAUSED);

`ifdef IMAGE_SEQ_BOUNCE_EN
   localparam logic [11:0] X_LIM = 12'(H_ACTIVE - IMG_W);
   localparam logic [11:0] Y_LIM = 12'(V_ACTIVE - IMG_H);

   axis_t x_reg;
   axis_t y_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_reg <= '{pos: X_START, dec: 1'b1};
         y_reg <= '{pos: Y_START, dec: 1'b1};
      end else if (frame_start && (state_reg == ST_AUTO)) begin
         x_reg <= bounce_step(x_reg, X_LIM);
         y_reg <= bounce_step(y_reg, Y_LIM);
      end
   end

   assign img_xpos = x_reg.pos;
   assign img_ypos = y_reg.pos;
`else
   assign img_xpos = X_START;
   assign img_ypos = Y_START;
`endif

endmodule

// File: tb/tb_image_seq_ctl.sv
// Randomized self-checking bench for image_seq_ctl against a transaction-level slideshow model.
// Bounce checks are compiled in when IMAGE_SEQ_BOUNCE_EN is defined.
module tb_image_seq_ctl;
   import vga_pkg::*;

   localparam int F    = 2;
   localparam int XS   = 1;
   localparam int YS   = 5;
   localparam int XMAX = H_ACTIVE - IMG_W;
   localparam int YMAX = V_ACTIVE - IMG_H;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        btn_next = 1'b0;
   logic        btn_pause = 1'b0;
   logic [2:0]  img_sel;
   logic [11:0] img_xpos;
   logic [11:0] img_ypos;
   logic        paused;

   vga_if vif ();

   image_seq_ctl #(
      .FRAMES_PER_IMG (F),
      .X_START        (12'(XS)),
      .Y_START        (12'(YS))
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in        (vif),
      .btn_next  (btn_next),
      .btn_pause (btn_pause),
      .img_sel   (img_sel),
      .img_xpos  (img_xpos),
      .img_ypos  (img_ypos),
      .paused    (paused)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: what the slideshow should show, in terms of frames and button events.
   int m_sel, m_cnt, m_pending, m_paused, m_moves;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Bouncing position is a triangle wave of the number of moving frames.
   function automatic int tri_pos(input int s, input int k, input int m);
      int r;
      r = (s - k) % (2 * m);
      if (r < 0) r += 2 * m;
      return (r <= m) ? r : 2 * m - r;
   endfunction

   function automatic int exp_x();
`ifdef IMAGE_SEQ_BOUNCE_EN
      return tri_pos(XS, m_moves, XMAX);
`else
      return XS;
`endif
   endfunction

   function automatic int exp_y();
`ifdef IMAGE_SEQ_BOUNCE_EN
      return tri_pos(YS, m_moves, YMAX);
`else
      return YS;
`endif
   endfunction

   task automatic model_reset();
      m_sel = 0; m_cnt = 0; m_pending = 0; m_paused = 0; m_moves = 0;
   endtask

   task automatic model_frame();
      if (m_pending != 0 || (m_paused == 0 && m_cnt == F - 1)) begin
         m_sel = (m_sel + 1) % NUM_IMG;
         m_cnt = 0;
      end else if (m_paused == 0) begin
         m_cnt++;
      end
      m_pending = 0;
      if (m_paused == 0) m_moves++;
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, "_sel"}, int'(img_sel), m_sel);
      check_val({tag, "_paused"}, int'(paused), m_paused);
      check_val({tag, "_xpos"}, int'(img_xpos), exp_x());
      check_val({tag, "_ypos"}, int'(img_ypos), exp_y());
      $display("%0t %s sel=%0d paused=%0d x=%0d y=%0d", $time, tag, img_sel, paused,
               img_xpos, img_ypos);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One vblnk rise; with_next raises btn_next on the same cycle so both edges land together.
   task automatic frame(input bit with_next);
      @(negedge clk);
      vif.vblnk = 1'b1;
      if (with_next) btn_next = 1'b1;
      @(posedge clk);
      #1;
      check_val("sel_before_update", int'(img_sel), m_sel);
      model_frame();
      if (with_next) m_pending = 1;
      @(posedge clk);
      #1;
      check_outputs(with_next ? "frame_next" : "frame");
      @(negedge clk);
      vif.vblnk = 1'b0;
      btn_next  = 1'b0;
      idle($urandom_range(1, 3));
   endtask

   task automatic pulse_next();
      @(negedge clk);
      btn_next = 1'b1;
      idle($urandom_range(1, 3));
      btn_next = 1'b0;
      idle(2);
      m_pending = 1;
      $display("%0t next pulse", $time);
   endtask

   task automatic pulse_pause();
      @(negedge clk);
      btn_pause = 1'b1;
      idle($urandom_range(1, 3));
      btn_pause = 1'b0;
      idle(2);
      m_paused = 1 - m_paused;
      #1;
      check_outputs("pause");
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs("reset_asserted");
      idle(2);
      rst = 1'b1;
      idle(2);
      #1;
      check_outputs("reset_released");
   endtask

   initial begin
      int guard;
      vif.vblnk = 1'b0;
      model_reset();
      idle(3);
      #1;
      check_outputs("reset_state");
      @(negedge clk);
      rst = 1'b1;
      idle(2);

      // Free-running wrap through all images.
      repeat (13) frame(1'b0);

      // Pause holds the image, unpause resumes.
      pulse_pause();
      repeat (5) frame(1'b0);
      pulse_pause();
      repeat (3) frame(1'b0);

      // Next while paused steps once and stays paused.
      pulse_pause();
      frame(1'b0);
      pulse_next();
      frame(1'b0);
      frame(1'b0);
      pulse_pause();
      repeat (3) frame(1'b0);

      // Next coincident with the 5->0 auto-advance frame.
      guard = 0;
      while (!(m_sel == NUM_IMG - 1 && m_cnt == F - 1) && guard < 20) begin
         frame(1'b0);
         guard++;
      end
      check_val("reach_wrap_point", (m_sel == NUM_IMG - 1 && m_cnt == F - 1) ? 1 : 0, 1);
      frame(1'b1);
      frame(1'b0);
      frame(1'b0);

      // Reset mid-hold discards a pending next.
      frame(1'b0);
      pulse_next();
      do_reset();
      repeat (3) frame(1'b0);

      // Random mix of events.
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: frame(1'b0);
            6:                frame(1'b1);
            7:                pulse_next();
            8:                pulse_pause();
            default: begin
               if ($urandom_range(0, 3) == 0) do_reset();
               else frame(1'b0);
            end
         endcase
      end

`ifdef IMAGE_SEQ_BOUNCE_EN
      if (m_paused != 0) pulse_pause();
      for (int i = 0; i < 1400; i++) begin
         frame(1'b0);
         check_val("xpos_in_range", (int'(img_xpos) <= XMAX) ? 1 : 0, 1);
         check_val("ypos_in_range", (int'(img_ypos) <= YMAX) ? 1 : 0, 1);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
